data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Two-requester controller and arbiter for the 32-word data memory. It accepts load/store requests from the core LSU (port 0) and the DMA/loader (port 1), picks one per slot, and sequences the memory's two-phase protocol. That protocol has two rules: the address is registered from `r_addr` first, and the write lands at the registered address when `wren` is low in the following cycle. The block sits between both requesters and the memory instance. It owns every memory control pin.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1. 1 selects round-robin arbitration; 0 gives port 0 fixed priority.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `p0_req`, `p1_req`  in  1  request. Held with its fields stable until the port's `gnt`.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  5  word address.
- `p0_wdata`, `p1_wdata`  in  32  store data.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle accept pulse; fields are captured on that edge.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: load data valid.
- `p0_rdata`, `p1_rdata`  out  32  load data; holds its value until the next load completes on that port.
- `busy`  out  1  high while a transaction is in ADDR or ACCESS.
- `mem_wren`  out  1  memory write enable, active-low (0 = write).
- `mem_is_store`  out  1  high during the ACCESS phase of a store.
- `mem_r_addr`, `mem_w_addr`  out  5  both driven with the captured address.
- `mem_w_data`  out  32  captured store data.
- `mem_r_data`  in  32  memory read data; valid one cycle after the address edge.

## Operation
- FSM states: IDLE, ADDR, ACCESS.
- IDLE:
  - If any `req` is high, assert the winner's `gnt` combinationally in that cycle.
  - On the edge, latch owner, `we`, `addr` and `wdata`, then go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - Drive `mem_r_addr`/`mem_w_addr` = captured address, `mem_wren` = 1.
  - The memory registers the address on the edge. Go to ACCESS.
- ACCESS, store:
  - `mem_wren` = 0, `mem_is_store` = 1, `mem_w_data` = captured data.
  - The address outputs are still held, so the write lands at the captured address on the edge.
  - Go to IDLE.
- ACCESS, load:
  - `mem_wren` = 1. Register `mem_r_data` into the owner's `rdata`.
  - Assert the owner's `rvalid` in the next cycle. Go to IDLE.
- Stores are posted and have no completion pulse. Ordering across ports is strict acceptance order.
- Arbitration:
  - `last` register, reset value 1, so port 0 wins the first tie.
  - With ROUND_ROBIN=1 and both requesting, grant the port ≠ `last`. Update `last` on every grant.
  - With ROUND_ROBIN=0, port 0 always wins ties.
  - A single requester always wins.
- `mem_wren` = 1 in every state except ACCESS-store.
- `mem_wren` is forced to 1 combinationally whenever `rst_n` = 0, so a reset never lets a write through.

## Timing
- Reset values:
  - state IDLE; `last` = 1.
  - `gnt`, `rvalid`, `rdata`, `busy`, `mem_is_store`, address outputs, `mem_w_data` all 0.
  - `mem_wren` = 1.
- Load accepted in cycle T: ADDR in T+1, ACCESS in T+2, `rvalid` high in T+3 (latency 3). A new grant is possible in T+3.
- Store accepted in cycle T: `mem_wren` = 0 only in T+2. Memory contents are updated at the end of T+2. A new grant is possible in T+3.
- Throughput is one transaction per 3 cycles. `gnt` never fires while `busy` = 1.
- A losing requester keeps `req` high and is granted at the next IDLE (3 cycles later).
- A request withdrawn before `gnt` is ignored. There is no abort after `gnt`.
- Reset asserted in ADDR or ACCESS:
  - The transaction is dropped and any pending `rvalid` is cancelled.
  - No memory write occurs in the reset cycle.
  - The block is in IDLE after the edge.
- Store followed by a load to the same address returns the new data, from either port.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with both `req` high and `p0_we` = 1. Required: no `gnt`, `mem_wren` = 1 throughout, all other outputs 0.
- Single port round trip:
  - p0 stores 0xDEADBEEF to addr 5: `p0_gnt` in T, `mem_wren` = 0 only in T+2.
  - p0 then loads addr 5: `p0_rvalid` exactly 3 cycles after its `gnt`, with `p0_rdata` = 0xDEADBEEF.
- Round-robin (ROUND_ROBIN=1): both ports hold loads to addr 1 (contents 0x11) and addr 2 (contents 0x22).
  - Grants go p0, p1, p0, … spaced 3 cycles apart.
  - Each `rvalid` shows that port's data.
- Fixed priority (ROUND_ROBIN=0): both ports request continuously. Required: only `p0_gnt` fires; `p1_gnt` fires in the first IDLE after `p0_req` drops.
- Reset mid-store:
  - p1 stores 0x12345678 to addr 9 over old contents 0xAAAA0000, with `rst_n` = 0 during that store's ACCESS cycle.
  - Required: `mem_wren` stays 1; after reset, a load of addr 9 returns 0xAAAA0000.
- Cross-port ordering: p1 stores 0x5 to addr 31, then p0 loads addr 31 on the next grant. Required: `p0_rdata` = 0x5.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Requester and memory-side signals of the two-port data memory controller.
// The controller attaches to the slave modport; requesters and memory attach to the master side.
interface data_mem_ctrl_if;
  logic        p0_req;
  logic        p0_we;
  logic [4:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [4:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;

  logic        busy;
  logic        mem_wren;
  logic        mem_is_store;
  logic [4:0]  mem_r_addr;
  logic [4:0]  mem_w_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_r_data,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output busy, mem_wren, mem_is_store, mem_r_addr, mem_w_addr, mem_w_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_r_data,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  busy, mem_wren, mem_is_store, mem_r_addr, mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Two-port arbiter/sequencer for the 32-word data memory: IDLE (grant) -> ADDR -> ACCESS.
// Load latency 3 cycles from grant; one transaction per 3 cycles; losers hold req until granted.
module data_mem_ctrl #(
  parameter int ROUND_ROBIN = 1
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;

  logic both_req;
  logic winner;
  logic grant;
  logic in_access;

  assign both_req  = bus.p0_req & bus.p1_req;
  // With both requesting, round-robin favours the port that did not win last.
  assign winner    = both_req ? ((ROUND_ROBIN != 0) ? ~last_q : 1'b0) : bus.p1_req;
  assign grant     = rst_n & (state_q == S_IDLE) & (bus.p0_req | bus.p1_req);
  assign in_access = (state_q == S_ACCESS);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ADDR;
          last_d  = winner;
          owner_d = winner;
          we_d    = winner ? bus.p1_we    : bus.p0_we;
          addr_d  = winner ? bus.p1_addr  : bus.p0_addr;
          wdata_d = winner ? bus.p1_wdata : bus.p0_wdata;
        end
      end
      S_ADDR: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d  = bus.mem_r_data;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = bus.mem_r_data;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 5'd0;
      wdata_q   <= 32'd0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign bus.p0_gnt    = grant & ~winner;
  assign bus.p1_gnt    = grant & winner;
  assign bus.p0_rvalid = rvalid0_q;
  assign bus.p1_rvalid = rvalid1_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.mem_is_store = in_access & we_q;
  // Reset gates the write strobe combinationally so an aborted store never reaches the array.
  assign bus.mem_wren     = ~(rst_n & in_access & we_q);
  assign bus.mem_r_addr   = addr_q;
  assign bus.mem_w_addr   = addr_q;
  assign bus.mem_w_data   = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: round-robin and fixed-priority instances, each with a behavioural memory.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  data_mem_ctrl_if r_if ();
  data_mem_ctrl_if f_if ();

  data_mem_ctrl #(.ROUND_ROBIN(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(r_if.slave));
  data_mem_ctrl #(.ROUND_ROBIN(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(f_if.slave));

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       return 32'h0000_0011;
      2:       return 32'h0000_0022;
      9:       return 32'hAAAA_0000;
      default: return (i * 32'h0101_0101) ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Memory: address registered every edge, write lands at the registered address while wren is low.
  logic [31:0] mem_r [32];
  logic [31:0] mem_f [32];
  logic [4:0]  ra_r, ra_f;
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= init_val(i);
        mem_f[i] <= init_val(i);
      end
      init_done <= 1'b1;
    end else begin
      if (!r_if.mem_wren) mem_r[ra_r] <= r_if.mem_w_data;
      if (!f_if.mem_wren) mem_f[ra_f] <= f_if.mem_w_data;
    end
    ra_r <= r_if.mem_r_addr;
    ra_f <= f_if.mem_r_addr;
  end
  assign r_if.mem_r_data = mem_r[ra_r];
  assign f_if.mem_r_data = mem_f[ra_f];

  logic [31:0] ref_mem [32];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [4:0] a, input logic [31:0] d);
    if (port) begin
      r_if.p1_req = req; r_if.p1_we = we; r_if.p1_addr = a; r_if.p1_wdata = d;
    end else begin
      r_if.p0_req = req; r_if.p0_we = we; r_if.p0_addr = a; r_if.p0_wdata = d;
    end
  endtask

  function automatic bit gnt_of(input bit port);
    return port ? r_if.p1_gnt : r_if.p0_gnt;
  endfunction

  // Issue one transaction on the round-robin instance and check its full timeline against ref_mem.
  task automatic txn(input bit port, input bit we, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] exp;
    int w;
    drive(port, 1'b1, we, a, d);
    #1;
    w = 0;
    while (!gnt_of(port) && w < 6) begin
      tick();
      w++;
    end
    chk("txn_gnt", {31'd0, gnt_of(port)}, 32'd1);
    if (!gnt_of(port)) begin
      drive(port, 1'b0, 1'b0, 5'd0, 32'd0);
      return;
    end
    chk("txn_other_gnt", {31'd0, gnt_of(~port)}, 32'd0);
    exp = ref_mem[a];
    if (we) ref_mem[a] = d;
    tick();
    drive(port, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("addr_busy", {31'd0, r_if.busy}, 32'd1);
    chk("addr_wren", {31'd0, r_if.mem_wren}, 32'd1);
    chk("addr_raddr", {27'd0, r_if.mem_r_addr}, {27'd0, a});
    tick();
    chk("acc_wren", {31'd0, r_if.mem_wren}, {31'd0, ~we});
    chk("acc_is_store", {31'd0, r_if.mem_is_store}, {31'd0, we});
    chk("acc_waddr", {27'd0, r_if.mem_w_addr}, {27'd0, a});
    if (we) chk("acc_wdata", r_if.mem_w_data, d);
    tick();
    chk("done_busy", {31'd0, r_if.busy}, 32'd0);
    chk("done_rvalid", {31'd0, port ? r_if.p1_rvalid : r_if.p0_rvalid}, {31'd0, ~we});
    chk("done_other_rvalid", {31'd0, port ? r_if.p0_rvalid : r_if.p1_rvalid}, 32'd0);
    if (!we) chk("done_rdata", port ? r_if.p1_rdata : r_if.p0_rdata, exp);
  endtask

  // Accept a transaction, then assert reset during its ACCESS cycle; it must leave no trace.
  task automatic rst_mid(input bit port, input bit we, input logic [4:0] a, input logic [31:0] d);
    int w;
    drive(port, 1'b1, we, a, d);
    #1;
    w = 0;
    while (!gnt_of(port) && w < 6) begin
      tick();
      w++;
    end
    chk("rst_mid_gnt", {31'd0, gnt_of(port)}, 32'd1);
    tick();
    drive(port, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wren", {31'd0, r_if.mem_wren}, 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, r_if.busy}, 32'd0);
    chk("rst_mid_rvalid", {30'd0, r_if.p1_rvalid, r_if.p0_rvalid}, 32'd0);
  endtask

  int g_port [0:31];
  int ng, nrv, lastg, n_p0, n_p1;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    rst_n = 1'b0;
    r_if.p0_req = 1'b1; r_if.p0_we = 1'b1; r_if.p0_addr = 5'd3; r_if.p0_wdata = 32'h1;
    r_if.p1_req = 1'b1; r_if.p1_we = 1'b0; r_if.p1_addr = 5'd4; r_if.p1_wdata = 32'h2;
    f_if.p0_req = 1'b1; f_if.p0_we = 1'b1; f_if.p0_addr = 5'd3; f_if.p0_wdata = 32'h1;
    f_if.p1_req = 1'b1; f_if.p1_we = 1'b0; f_if.p1_addr = 5'd4; f_if.p1_wdata = 32'h2;

    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_gnt", {30'd0, r_if.p1_gnt, r_if.p0_gnt}, 32'd0);
      chk("rst_fp_gnt", {30'd0, f_if.p1_gnt, f_if.p0_gnt}, 32'd0);
      chk("rst_wren", {31'd0, r_if.mem_wren}, 32'd1);
      chk("rst_fp_wren", {31'd0, f_if.mem_wren}, 32'd1);
      chk("rst_flags", {28'd0, r_if.busy, r_if.mem_is_store, r_if.p1_rvalid, r_if.p0_rvalid}, 32'd0);
      chk("rst_addr", {22'd0, r_if.mem_r_addr, r_if.mem_w_addr}, 32'd0);
      chk("rst_wdata", r_if.mem_w_data, 32'd0);
      chk("rst_rdata", r_if.p0_rdata | r_if.p1_rdata, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    f_if.p0_req = 1'b0; f_if.p1_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Round-robin: both ports hold loads continuously.
    for (int i = 0; i < 32; i++) g_port[i] = -1;
    drive(1'b0, 1'b1, 1'b0, 5'd1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    #1;
    ng = 0; nrv = 0; lastg = -1;
    for (int c = 0; c < 19; c++) begin
      if (c > 0) begin
        tick();
        if (ng == 6 && lastg < c) begin
          drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
          drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
          #1;
        end
      end
      if (r_if.p0_gnt || r_if.p1_gnt) begin
        chk("rr_one_gnt", {31'd0, r_if.p0_gnt & r_if.p1_gnt}, 32'd0);
        chk("rr_order", {31'd0, r_if.p1_gnt}, ng % 2);
        if (lastg >= 0) chk("rr_spacing", c - lastg, 32'd3);
        g_port[c] = int'(r_if.p1_gnt);
        lastg = c;
        ng++;
      end
      if (r_if.p0_rvalid || r_if.p1_rvalid) begin
        nrv++;
        chk("rr_rv_port", {31'd0, r_if.p1_rvalid}, (c >= 3) ? g_port[c-3] : -1);
        chk("rr_rv_data", r_if.p1_rvalid ? r_if.p1_rdata : r_if.p0_rdata,
            r_if.p1_rvalid ? ref_mem[2] : ref_mem[1]);
      end
    end
    chk("rr_ngnt", ng, 32'd6);
    chk("rr_nrv", nrv, 32'd6);

    // Fixed priority: p1 only wins once p0 stops asking.
    f_if.p0_req = 1'b1; f_if.p0_we = 1'b0; f_if.p0_addr = 5'd3;
    f_if.p1_req = 1'b1; f_if.p1_we = 1'b0; f_if.p1_addr = 5'd4;
    #1;
    n_p0 = 0; n_p1 = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        tick();
        if (c == 7) f_if.p0_req = 1'b0;
        if (c == 10) f_if.p1_req = 1'b0;
        #1;
      end
      if (f_if.p0_gnt) begin
        n_p0++;
        chk("fp_p0_early", {31'd0, c < 7}, 32'd1);
      end
      if (f_if.p1_gnt) begin
        n_p1++;
        chk("fp_p1_cycle", c, 32'd9);
      end
      if (f_if.p0_rvalid) chk("fp_p0_rdata", f_if.p0_rdata, init_val(3));
      if (f_if.p1_rvalid) chk("fp_p1_rdata", f_if.p1_rdata, init_val(4));
    end
    chk("fp_n_p0", n_p0, 32'd3);
    chk("fp_n_p1", n_p1, 32'd1);

    // Single-port round trip, then cross-port ordering.
    txn(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 5'd5, 32'd0);
    txn(1'b1, 1'b1, 5'd31, 32'h0000_0005);
    txn(1'b0, 1'b0, 5'd31, 32'd0);

    // Reset in the middle of a store, then of a load.
    rst_mid(1'b1, 1'b1, 5'd9, 32'h1234_5678);
    txn(1'b0, 1'b0, 5'd9, 32'd0);
    rst_mid(1'b0, 1'b0, 5'd9, 32'd0);
    txn(1'b1, 1'b0, 5'd9, 32'd0);

    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
